// File: rtl/lcd_patgen_pkg.sv
// Shared types, colour constants and pixel helpers for the LCD test-pattern writer.
package lcd_patgen_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_RAMP    = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_GAP
    } state_e;

    localparam logic [23:0] BLACK   = 24'h000000;
    localparam logic [23:0] WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RED     = 24'hFF0000;
    localparam logic [23:0] GREEN   = 24'h00FF00;
    localparam logic [23:0] BLUE    = 24'h0000FF;
    localparam logic [23:0] YELLOW  = 24'hFFFF00;
    localparam logic [23:0] CYAN    = 24'h00FFFF;
    localparam logic [23:0] MAGENTA = 24'hFF00FF;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return WHITE;
            3'd1:    return YELLOW;
            3'd2:    return CYAN;
            3'd3:    return GREEN;
            3'd4:    return MAGENTA;
            3'd5:    return RED;
            3'd6:    return BLUE;
            default: return BLACK;
        endcase
    endfunction

    function automatic logic [23:0] solid_color(input logic [1:0] idx);
        case (idx)
            2'd0:    return BLACK;
            2'd1:    return RED;
            2'd2:    return BLUE;
            default: return GREEN;
        endcase
    endfunction

    // RGB565 sits in the low 16 bits; RGB888 passes through unchanged.
    function automatic logic [23:0] pack_pixel(input logic [23:0] rgb, input int unsigned pix_w);
        if (pix_w == 16)
            return {8'h00, rgb[23:19], rgb[15:10], rgb[7:3]};
        return rgb;
    endfunction

endpackage

// File: rtl/lcd_patgen_if.sv
// FIFO write-port bundle between the pattern writer (master) and SDRAM write FIFO (slave).
interface lcd_patgen_if #(
    parameter int PIX_W = 16
);
    logic             wr_en;
    logic [PIX_W-1:0] wr_data;
    logic             wr_full;

    modport master (output wr_en, output wr_data, input wr_full);
    modport slave  (input wr_en, input wr_data, output wr_full);
endinterface

// File: rtl/lcd_patgen_xy.sv
// Pixel position counters that advance only on accepted writes, plus bar index and
// checkerboard/first/last-pixel flags derived from the position.
module lcd_patgen_xy
    import lcd_patgen_pkg::*;
#(
    parameter int H_DISP    = 800,
    parameter int V_DISP    = 480,
    parameter int CHK_SHIFT = 5
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       clear,
    input  logic       advance,
    output logic [7:0] x_lo,
    output logic [2:0] bar_idx,
    output logic       chk_on,
    output logic       first_pixel,
    output logic       last_pixel
);
    localparam int          BAR_W     = H_DISP / 8;
    localparam logic [2:0]  BAR_START = (BAR_W == 0) ? 3'd7 : 3'd0;
    localparam logic [15:0] BAR_LAST  = 16'((BAR_W == 0) ? 0 : BAR_W - 1);
    localparam logic [15:0] X_LAST    = 16'(H_DISP - 1);
    localparam logic [15:0] Y_LAST    = 16'(V_DISP - 1);

    logic [15:0] x, y, bar_cnt;

    // Bar index tracks x with a sub-counter; bar 7 absorbs any remainder pixels.
    always_ff @(posedge clk_50m) begin
        if (rst || clear) begin
            x       <= '0;
            y       <= '0;
            bar_cnt <= '0;
            bar_idx <= BAR_START;
        end else if (advance) begin
            if (x == X_LAST) begin
                x       <= '0;
                y       <= (y == Y_LAST) ? '0 : y + 16'd1;
                bar_cnt <= '0;
                bar_idx <= BAR_START;
            end else begin
                x <= x + 16'd1;
                if (bar_idx != 3'd7 && bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + 16'd1;
                end
            end
        end
    end

    assign x_lo        = x[7:0];
    assign chk_on      = x[CHK_SHIFT] ^ y[CHK_SHIFT];
    assign first_pixel = (x == '0) && (y == '0);
    assign last_pixel  = (x == X_LAST) && (y == Y_LAST);
endmodule

// File: rtl/lcd_pattern_gen.sv
// Test-pattern frame writer feeding the SDRAM write FIFO with back-pressure.
// Define LCD_PATGEN_CHECKER_EN to give mode 3 a checkerboard; otherwise mode 3 = solid.
module lcd_pattern_gen
    import lcd_patgen_pkg::*;
#(
    parameter int H_DISP           = 800,
    parameter int V_DISP           = 480,
    parameter int PIX_W            = 16,
    parameter int GAP_CYCLES       = 16,
    parameter int FRAMES_PER_COLOR = 200,
    parameter int CHK_SHIFT        = 5
) (
    input  logic          clk_50m,
    input  logic          rst,
    input  logic          sdram_init_done,
    input  logic [1:0]    mode,
    lcd_patgen_if.master  wr_if,
    output logic          frame_start,
    output logic          frame_done,
    output logic          busy
);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] FRAME_LAST = 16'(FRAMES_PER_COLOR - 1);

    state_e      state, state_n;
    mode_e       mode_q;
    logic [15:0] gap_cnt, frame_cnt;
    logic [1:0]  color_idx;
    logic        wr_en;
    logic [7:0]  x_lo;
    logic [2:0]  bar_idx;
    logic        chk_on, first_pixel, last_pixel;
    logic [23:0] pix24;

    lcd_patgen_xy #(
        .H_DISP    (H_DISP),
        .V_DISP    (V_DISP),
        .CHK_SHIFT (CHK_SHIFT)
    ) u_xy (
        .clk_50m     (clk_50m),
        .rst         (rst),
        .clear       (state != ST_ACTIVE),
        .advance     (wr_en),
        .x_lo        (x_lo),
        .bar_idx     (bar_idx),
        .chk_on      (chk_on),
        .first_pixel (first_pixel),
        .last_pixel  (last_pixel)
    );

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_SOLID;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            color_idx <= '0;
        end else begin
            state   <= state_n;
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 16'd1 : '0;
            if (state != ST_ACTIVE && state_n == ST_ACTIVE)
                mode_q <= mode_e'(mode);
            if (frame_done) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    color_idx <= color_idx + 2'd1;
                end else begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        wr_en   = 1'b0;
        case (state)
            ST_IDLE:   if (sdram_init_done) state_n = ST_ACTIVE;
            ST_ACTIVE: begin
                wr_en = !wr_if.wr_full;
                if (wr_en && last_pixel) state_n = ST_GAP;
            end
            ST_GAP:    if (gap_cnt == GAP_LAST)
                           state_n = sdram_init_done ? ST_ACTIVE : ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        pix24 = BLACK;
        case (mode_q)
            MODE_SOLID:   pix24 = solid_color(color_idx);
            MODE_BARS:    pix24 = bar_color(bar_idx);
            MODE_RAMP:    pix24 = {3{x_lo}};
`ifdef LCD_PATGEN_CHECKER_EN
            MODE_CHECKER: pix24 = chk_on ? WHITE : BLACK;
`else
            MODE_CHECKER: pix24 = solid_color(color_idx);
`endif
            default:      pix24 = BLACK;
        endcase
    end

`ifndef LCD_PATGEN_CHECKER_EN
    logic chk_unused;
    assign chk_unused = chk_on;
`endif

    assign wr_if.wr_en   = wr_en;
    assign wr_if.wr_data = wr_en ? PIX_W'(pack_pixel(pix24, PIX_W)) : '0;
    assign frame_start   = wr_en && first_pixel;
    assign frame_done    = wr_en && last_pixel;
    assign busy          = (state != ST_IDLE);
endmodule
